// File: rtl/control_seq.sv
// Instruction sequencer: INIT -> FETCH (multi-word) -> DECODE -> EXECUTE -> FETCH,
// with a HALT state that is left on resume.
// Ports:
//   clk, rst_async_n          clock, asynchronous active-low reset
//   imem_req/imem_addr/ack    instruction fetch handshake (addr tracks pc)
//   ir_load, ir_word_sel      instruction-register write strobe and slot
//   dec_*                     decoder results, sampled in DECODE
//   stall, resume             execute freeze, leave HALT
//   exec_en, exec_last        execute datapath enable, final execute cycle
//   pc, halted, state_o       program counter, HALT flag, encoded state
module control_seq #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WORDS = 2,
  parameter int unsigned CYC_WIDTH   = 4,
  localparam int unsigned WSEL_WIDTH = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_async_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  output logic                  ir_load,
  output logic [WSEL_WIDTH-1:0] ir_word_sel,
  input  logic [CYC_WIDTH-1:0]  dec_exec_cycles,
  input  logic                  dec_branch,
  input  logic [ADDR_WIDTH-1:0] dec_target,
  input  logic                  dec_halt,
  input  logic                  stall,
  input  logic                  resume,
  output logic                  exec_en,
  output logic                  exec_last,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic [2:0]            state_o
);

  localparam logic [WSEL_WIDTH-1:0] LAST_WORD = WSEL_WIDTH'(INSTR_WORDS - 1);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [WSEL_WIDTH-1:0] wsel_q, wsel_d;
  logic [CYC_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  br_q, br_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= ST_INIT;
      pc_q    <= '0;
      wsel_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wsel_q  <= wsel_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state, datapath updates and per-state outputs
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wsel_d    = wsel_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    tgt_d     = tgt_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    exec_en   = 1'b0;
    exec_last = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        if (imem_ack) begin
          pc_d = pc_q + ADDR_WIDTH'(1);
          if (wsel_q == LAST_WORD) begin
            wsel_d  = '0;
            state_d = ST_DECODE;
          end else begin
            wsel_d = wsel_q + WSEL_WIDTH'(1);
          end
        end
      end
      ST_DECODE: begin
        br_d    = dec_branch;
        tgt_d   = dec_target;
        cnt_d   = dec_exec_cycles;
        state_d = dec_halt ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exec_en = !stall;
        if (!stall) begin
          if (cnt_q == '0) begin
            exec_last = 1'b1;
            state_d   = ST_FETCH;
            if (br_q) pc_d = tgt_q;
          end else begin
            cnt_d = cnt_q - CYC_WIDTH'(1);
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume) state_d = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ir_word_sel = wsel_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq (ADDR_WIDTH=8, INSTR_WORDS=2, CYC_WIDTH=4).
module tb_control_seq;

  logic       clk = 1'b0;
  logic       rst_async_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic       ir_load;
  logic [0:0] ir_word_sel;
  logic [3:0] dec_exec_cycles;
  logic       dec_branch;
  logic [7:0] dec_target;
  logic       dec_halt;
  logic       stall;
  logic       resume;
  logic       exec_en;
  logic       exec_last;
  logic [7:0] pc;
  logic       halted;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  control_seq #(.ADDR_WIDTH(8), .INSTR_WORDS(2), .CYC_WIDTH(4)) dut (
    .clk(clk), .rst_async_n(rst_async_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .ir_load(ir_load), .ir_word_sel(ir_word_sel),
    .dec_exec_cycles(dec_exec_cycles), .dec_branch(dec_branch),
    .dec_target(dec_target), .dec_halt(dec_halt),
    .stall(stall), .resume(resume),
    .exec_en(exec_en), .exec_last(exec_last),
    .pc(pc), .halted(halted), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ack;
    logic [3:0] ec;
    logic       br;
    logic [7:0] tgt;
    logic       hlt;
    logic       stl;
    logic       res;
    logic [2:0] st;
    logic       req;
    logic [7:0] addr;
    logic       ld;
    logic       sel;
    logic       en;
    logic       last;
    logic       hl;
  } vec_t;

  vec_t vec_a[$];
  vec_t vec_b[$];
  vec_t sb[$];

  // inputs: ack ec br tgt hlt stl res | expected: st req addr ld sel en last halted
  function automatic vec_t mk(logic ack, logic [3:0] ec, logic br, logic [7:0] tgt,
                              logic hlt, logic stl, logic res, logic [2:0] st,
                              logic req, logic [7:0] addr, logic ld, logic sel,
                              logic en, logic last, logic hl);
    vec_t v;
    v.ack = ack; v.ec = ec; v.br = br; v.tgt = tgt; v.hlt = hlt; v.stl = stl;
    v.res = res; v.st = st; v.req = req; v.addr = addr; v.ld = ld; v.sel = sel;
    v.en = en; v.last = last; v.hl = hl;
    return v;
  endfunction

  task automatic chk(input string name, input int tag, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  task automatic compare_out(input vec_t e, input int tag);
    chk("state_o",     tag, 8'(state_o),     8'(e.st));
    chk("imem_req",    tag, 8'(imem_req),    8'(e.req));
    chk("imem_addr",   tag, imem_addr,       e.addr);
    chk("pc",          tag, pc,              e.addr);
    chk("ir_load",     tag, 8'(ir_load),     8'(e.ld));
    chk("ir_word_sel", tag, 8'(ir_word_sel), 8'(e.sel));
    chk("exec_en",     tag, 8'(exec_en),     8'(e.en));
    chk("exec_last",   tag, 8'(exec_last),   8'(e.last));
    chk("halted",      tag, 8'(halted),      8'(e.hl));
  endtask

  task automatic drive(input vec_t v);
    imem_ack        = v.ack;
    dec_exec_cycles = v.ec;
    dec_branch      = v.br;
    dec_target      = v.tgt;
    dec_halt        = v.hlt;
    stall           = v.stl;
    resume          = v.res;
  endtask

  // Drive one cycle's inputs at the falling edge, queue the expectation, check 1ns later
  task automatic apply(input vec_t v, input int tag, input bit release_rst);
    vec_t e;
    @(negedge clk);
    if (release_rst) rst_async_n = 1'b1;
    drive(v);
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    compare_out(e, tag);
  endtask

  task automatic check_reset_now(input int tag);
    vec_t z;
    z = mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 0);
    sb.push_back(z);
    #1;
    z = sb.pop_front();
    compare_out(z, tag);
  endtask

  initial begin
    // Scenario 2 from reset, then multi-cycle execute with stall, branch wrap, halt/resume
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h00, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 1, 0, 3'd1, 1, 8'h00, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h00, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h00, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h01, 1, 1, 0, 0, 0));
    vec_a.push_back(mk(1, 4'd3, 0, 8'h77, 0, 1, 0, 3'd2, 0, 8'h02, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h02, 0, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 1, 0, 3'd3, 0, 8'h02, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h02, 0, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h02, 0, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h02, 0, 0, 1, 1, 0));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h02, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h03, 1, 1, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 1, 8'hFE, 0, 0, 0, 3'd2, 0, 8'h04, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h04, 0, 0, 1, 1, 0));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'hFE, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'hFF, 1, 1, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd2, 1, 8'h55, 1, 0, 0, 3'd2, 0, 8'h00, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd4, 0, 8'h00, 0, 0, 0, 0, 1));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 1, 1, 3'd4, 0, 8'h00, 0, 0, 0, 0, 1));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h00, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h00, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h01, 0, 1, 0, 0, 0));

    // Scenario 1 after a mid-fetch reset, continuing into a multi-cycle execute
    vec_b.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h00, 1, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h01, 1, 1, 0, 0, 0));
    vec_b.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd2, 0, 8'h02, 0, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h02, 0, 0, 1, 1, 0));
    vec_b.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h02, 0, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h02, 1, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 4'd0, 0, 8'h00, 0, 0, 0, 3'd1, 1, 8'h03, 1, 1, 0, 0, 0));
    vec_b.push_back(mk(0, 4'd2, 0, 8'h00, 0, 0, 0, 3'd2, 0, 8'h04, 0, 0, 0, 0, 0));
    vec_b.push_back(mk(0, 4'd0, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h04, 0, 0, 1, 0, 0));

    rst_async_n     = 1'b0;
    imem_ack        = 1'b1;
    dec_exec_cycles = 4'd0;
    dec_branch      = 1'b0;
    dec_target      = 8'h00;
    dec_halt        = 1'b0;
    stall           = 1'b0;
    resume          = 1'b0;

    // Outputs held at zero while reset is asserted across clock edges
    repeat (2) @(negedge clk);
    check_reset_now(1000);

    for (int i = 0; i < vec_a.size(); i++) apply(vec_a[i], i, i == 0);

    // Mid-fetch reset: outputs must clear before the next rising edge
    @(negedge clk);
    #2;
    rst_async_n = 1'b0;
    check_reset_now(2000);
    @(negedge clk);

    for (int i = 0; i < vec_b.size(); i++) apply(vec_b[i], 100 + i, i == 0);

    // Mid-execute reset with stall low: exec_en must drop immediately
    @(negedge clk);
    stall = 1'b0;
    #2;
    rst_async_n = 1'b0;
    check_reset_now(3000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of program counter and instruction memory address.
REQ-002 Parameter INSTR_WORDS, default 2, legal range 1..8: memory words fetched per instruction.
REQ-003 Parameter CYC_WIDTH, default 4: width of the execute-cycle count field.
REQ-004 Parameter WSEL_WIDTH, derived: max(1, clog2(INSTR_WORDS)).
REQ-005 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 Port rst_async_n  in  1  reset, asynchronous assert, active-low.
REQ-007 Port imem_req  out  1  instruction fetch request.
REQ-008 Port imem_addr  out  ADDR_WIDTH  fetch address; always equals pc.
REQ-009 Port imem_ack  in  1  memory has returned the requested word this cycle.
REQ-010 Port ir_load  out  1  write the returned word into the instruction register.
REQ-011 Port ir_word_sel  out  WSEL_WIDTH  instruction-register slot for ir_load.
REQ-012 Port dec_exec_cycles  in  CYC_WIDTH  number of execute cycles minus one.
REQ-013 Port dec_branch  in  1  the decoded instruction redirects the pc.
REQ-014 Port dec_target  in  ADDR_WIDTH  branch target address.
REQ-015 Port dec_halt  in  1  the decoded instruction is HALT.
REQ-016 Port stall  in  1  execute unit not ready; freezes EXECUTE.
REQ-017 Port resume  in  1  leave HALT.
REQ-018 Port exec_en  out  1  execute datapath enabled this cycle.
REQ-019 Port exec_last  out  1  final execute cycle of the instruction.
REQ-020 Port pc  out  ADDR_WIDTH  program counter.
REQ-021 Port halted  out  1  sequencer is in HALT.
REQ-022 Port state_o  out  3  encoded state: INIT=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4.

Function
REQ-023 The state machine SHALL have states INIT, FETCH, DECODE, EXECUTE and HALT.
REQ-024 INIT SHALL last exactly one cycle and SHALL then transition to FETCH.
REQ-025 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-026 In FETCH, ir_load SHALL be combinationally equal to imem_ack, and ir_word_sel SHALL equal the internal word index.
REQ-027 Each FETCH cycle with imem_ack=1 SHALL increment pc by 1, modulo 2^ADDR_WIDTH, and SHALL increment the word index.
REQ-028 While in FETCH with imem_ack=0, pc, the word index and imem_addr SHALL hold; the number of wait cycles is unbounded.
REQ-029 The INSTR_WORDS-th ack SHALL clear the word index to 0 and transition to DECODE; an ack in the first FETCH cycle (zero wait) is legal.
REQ-030 DECODE SHALL last one cycle and SHALL sample dec_exec_cycles, dec_branch, dec_target and dec_halt.
REQ-031 From DECODE, dec_halt=1 SHALL transition to HALT and SHALL take priority over dec_branch; otherwise the next state SHALL be EXECUTE with a down-counter loaded with dec_exec_cycles.
REQ-032 In EXECUTE, exec_en SHALL equal !stall.
REQ-033 The down-counter SHALL decrement only on cycles with exec_en=1.
REQ-034 exec_last SHALL be 1 when counter==0 and stall=0; the state SHALL then transition to FETCH.
REQ-035 On that transition, pc SHALL load the latched target if the latched branch is 1; otherwise pc SHALL be unchanged.
REQ-036 stall SHALL be ignored outside EXECUTE.
REQ-037 An instruction SHALL therefore produce exactly dec_exec_cycles+1 exec_en pulses.
REQ-038 In HALT, halted SHALL be 1; resume=1 SHALL transition to FETCH at the current pc.
REQ-039 imem_req, ir_load, exec_en, exec_last and halted SHALL be 0 in every state not named above for that output.

Reset
REQ-040 rst_async_n=0 SHALL immediately force state INIT, pc=0, word index=0, counter=0 and latched branch=0.
REQ-041 During reset, all outputs SHALL be 0 except state_o=0, including when reset asserts mid-fetch or mid-execute.
REQ-042 The first edge after rst_async_n rises SHALL leave INIT.

Verification (ADDR_WIDTH=8, INSTR_WORDS=2)
REQ-043 Scenario 1: release reset with ack=1 and exec_cycles=0 -> INIT at c0; FETCH with addr 0x00 at c1 and 0x01 at c2; DECODE at c3; EXECUTE with exec_last=1 at c4; FETCH with addr 0x02 at c5.
REQ-044 Scenario 2: ack withheld 3 cycles on the first word -> imem_addr held at 0x00 and pc=0 for 3 cycles, ir_load=0; then ir_load=1 with sel=0.
REQ-045 Scenario 3: exec_cycles=3 with stall=1 in the 2nd EXECUTE cycle -> 5 EXECUTE cycles, 4 exec_en pulses, exec_last only in the 5th.
REQ-046 Scenario 4: branch=1 with target=0xFE -> next fetch addresses 0xFE then 0xFF, after which pc wraps to 0x00.
REQ-047 Scenario 5: halt=1 and branch=1 in DECODE -> HALT with halted=1 and pc unchanged; resume pulse -> FETCH at the same pc.
REQ-048 Scenario 6: reset asserted mid-FETCH with imem_req=1 -> imem_req=0 and pc=0 without waiting for a clock edge; sequence restarts per Scenario 1.
